eth_mii_tx_framer: RTL and testbench

Nibble-wide Ethernet MII transmit sequencer. Accepts a byte stream (valid/ready/last) and emits preamble, SFD, payload, zero padding up to a minimum length, FCS, and inter-frame gap on MII.
Drives an external 4-bit CRC-32 engine and reads its next-state output. The engine seeds to all-ones, updates on crc_en, and reseeds on crc_en&crc_eof. Its crc_in is the combinational post-update value for the nibble currently presented. Sits between the TX frame buffer and the PHY pins.

---
 rtl/eth_mii_tx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_eth_mii_tx_framer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mii_tx_framer.sv
// Nibble-wide Ethernet MII transmit sequencer: preamble/SFD, payload, zero pad,
// FCS from an external 4-bit CRC-32 engine, and inter-frame gap.
module eth_mii_tx_framer #(
  parameter int unsigned PREAMBLE_NIBBLES = 15,
  parameter int unsigned MIN_BYTES        = 60,
  parameter int unsigned IFG_NIBBLES      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [3:0]  mii_txd,
  output logic        mii_tx_en,
  output logic        mii_tx_er,
  output logic        crc_en,
  output logic        crc_sof,
  output logic        crc_eof,
  output logic [3:0]  crc_data,
  input  logic [31:0] crc_in,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  hold_hi_q, hold_hi_d;
  logic        hold_last_q, hold_last_d;
  logic        first_q, first_d;
  logic [31:0] fcs_q, fcs_d;
  logic [3:0]  txd_d;
  logic        tx_en_d, tx_er_d, underrun_d;

  logic [16:0] byte_inc;
  logic        min_reached;
  logic [15:0] byte_sat;
  logic        ifg_done;

  assign byte_inc    = {1'b0, byte_cnt_q} + 17'd1;
  assign min_reached = byte_inc >= 17'(MIN_BYTES);
  assign byte_sat    = min_reached ? 16'(MIN_BYTES) : byte_inc[15:0];
  assign ifg_done    = ({1'b0, cnt_q} + 17'd1) >= 17'(IFG_NIBBLES);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    phase_d     = phase_q;
    hold_hi_d   = hold_hi_q;
    hold_last_d = hold_last_q;
    first_d     = first_q;
    fcs_d       = fcs_q;
    txd_d       = '0;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    underrun_d  = 1'b0;
    s_tready    = 1'b0;
    crc_en      = 1'b0;
    crc_sof     = 1'b0;
    crc_eof     = 1'b0;
    crc_data    = '0;
    busy        = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (s_tvalid) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end

      S_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q < 16'(PREAMBLE_NIBBLES)) begin
          txd_d = 4'h5;
          cnt_d = cnt_q + 16'd1;
        end else begin
          txd_d      = 4'hD;
          state_d    = S_DATA;
          cnt_d      = '0;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          first_d    = 1'b1;
        end
      end

      S_DATA: begin
        tx_en_d = 1'b1;
        if (!phase_q) begin
          s_tready = 1'b1;
          if (s_tvalid) begin
            txd_d       = s_tdata[3:0];
            crc_en      = 1'b1;
            crc_data    = s_tdata[3:0];
            crc_sof     = first_q;
            first_d     = 1'b0;
            hold_hi_d   = s_tdata[7:4];
            hold_last_d = s_tlast;
            phase_d     = 1'b1;
          end else begin
            tx_er_d    = 1'b1;
            underrun_d = 1'b1;
          end
        end else begin
          txd_d      = hold_hi_q;
          crc_en     = 1'b1;
          crc_data   = hold_hi_q;
          phase_d    = 1'b0;
          byte_cnt_d = byte_sat;
          if (hold_last_q) begin
            if (min_reached) begin
              crc_eof = 1'b1;
              fcs_d   = crc_in;
              state_d = S_FCS;
              cnt_d   = '0;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        tx_en_d  = 1'b1;
        crc_en   = 1'b1;
        phase_d  = ~phase_q;
        if (phase_q) begin
          byte_cnt_d = byte_sat;
          if (min_reached) begin
            crc_eof = 1'b1;
            fcs_d   = crc_in;
            state_d = S_FCS;
            cnt_d   = '0;
          end
        end
      end

      // FCS is shifted out MSB-first; each nibble goes on the wire bit-reversed and inverted
      S_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = ~{fcs_q[28], fcs_q[29], fcs_q[30], fcs_q[31]};
        fcs_d   = {fcs_q[27:0], 4'h0};
        cnt_d   = cnt_q + 16'd1;
        if (cnt_q == 16'd7) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end
      end

      // A pending frame skips IDLE so the gap on the wire is exactly IFG_NIBBLES
      S_IFG: begin
        if (ifg_done) begin
          state_d = s_tvalid ? S_PRE : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      phase_q     <= 1'b0;
      hold_hi_q   <= '0;
      hold_last_q <= 1'b0;
      first_q     <= 1'b0;
      fcs_q       <= '0;
      mii_txd     <= '0;
      mii_tx_en   <= 1'b0;
      mii_tx_er   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      phase_q     <= phase_d;
      hold_hi_q   <= hold_hi_d;
      hold_last_q <= hold_last_d;
      first_q     <= first_d;
      fcs_q       <= fcs_d;
      mii_txd     <= txd_d;
      mii_tx_en   <= tx_en_d;
      mii_tx_er   <= tx_er_d;
      underrun    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// Directed bench for eth_mii_tx_framer: two instances (default and MIN_BYTES=0),
// each with a behavioural nibble CRC-32 engine; MII traces recorded and checked.
module tb_eth_mii_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast;
  logic       use_b;

  logic        valid_a, valid_b;
  logic        rdy_a, rdy_b;
  logic [3:0]  txd_a, txd_b, cdat_a, cdat_b;
  logic        en_a, en_b, er_a, er_b;
  logic        cen_a, cen_b, sof_a, sof_b, eof_a, eof_b;
  logic        busy_a, busy_b, und_a, und_b;
  logic [31:0] crc_in_a, crc_in_b, eng_a, eng_b;

  assign valid_a = s_tvalid & ~use_b;
  assign valid_b = s_tvalid & use_b;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 4; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  assign crc_in_a = crc_nib(eng_a, cdat_a);
  assign crc_in_b = crc_nib(eng_b, cdat_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_a <= '1;
      eng_b <= '1;
    end else begin
      if (cen_a) eng_a <= eof_a ? '1 : crc_in_a;
      if (cen_b) eng_b <= eof_b ? '1 : crc_in_b;
    end
  end

  eth_mii_tx_framer dut_a (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(valid_a), .s_tlast(s_tlast),
    .s_tready(rdy_a), .mii_txd(txd_a), .mii_tx_en(en_a), .mii_tx_er(er_a),
    .crc_en(cen_a), .crc_sof(sof_a), .crc_eof(eof_a), .crc_data(cdat_a),
    .crc_in(crc_in_a), .busy(busy_a), .underrun(und_a)
  );

  eth_mii_tx_framer #(.MIN_BYTES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(valid_b), .s_tlast(s_tlast),
    .s_tready(rdy_b), .mii_txd(txd_b), .mii_tx_en(en_b), .mii_tx_er(er_b),
    .crc_en(cen_b), .crc_sof(sof_b), .crc_eof(eof_b), .crc_data(cdat_b),
    .crc_in(crc_in_b), .busy(busy_b), .underrun(und_b)
  );

  typedef struct packed {
    logic       en, er, und, sof, eof, cen, rdy, busy;
    logic [3:0] txd;
  } trace_t;

  trace_t ta_q[$], tb_q[$];

  always @(negedge clk) begin
    ta_q.push_back({en_a, er_a, und_a, sof_a, eof_a, cen_a, rdy_a, busy_a, txd_a});
    tb_q.push_back({en_b, er_b, und_b, sof_b, eof_b, cen_b, rdy_b, busy_b, txd_b});
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0] pay[$];
  logic [3:0] exp_q[$];

  task automatic build_exp(input int min_b);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    c = '1;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    n = (pay.size() > min_b) ? pay.size() : min_b;
    for (int i = 0; i < n; i++) begin
      b = (i < pay.size()) ? pay[i] : 8'h00;
      exp_q.push_back(b[3:0]); c = crc_nib(c, b[3:0]);
      exp_q.push_back(b[7:4]); c = crc_nib(c, b[7:4]);
    end
    for (int k = 0; k < 8; k++)
      exp_q.push_back(~{c[28-4*k], c[29-4*k], c[30-4*k], c[31-4*k]});
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    int   n;
    logic acc;
    n = 0; acc = 1'b0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = use_b ? rdy_b : rdy_a;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_frame(input int stall_after, input bit drop);
    for (int i = 0; i < pay.size(); i++) begin
      push_byte(pay[i], i == pay.size() - 1);
      if (i == stall_after) begin
        s_tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
      end
    end
    if (drop) s_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int   n;
    logic b;
    n = 0;
    do begin
      @(negedge clk);
      b = use_b ? busy_b : busy_a;
      n++;
    end while (b && n < 3000);
    if (b) chk("idle_timeout", {31'd0, b}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  int r_first, r_end, r_len, r_mis, r_er, r_und, r_sof, r_eof, r_cen, r_rdy, r_gap;
  logic [3:0] r_nib[$];

  // Walks one frame starting at trace index 'from': the tx_en run, then the idle gap after it
  task automatic analyze(input bit sel, input int from);
    trace_t t;
    int     ph, sz;
    r_first = -1; r_end = -1; r_len = 0; r_mis = 0; r_er = 0; r_und = 0;
    r_sof = 0; r_eof = 0; r_cen = 0; r_rdy = 0; r_gap = 0; ph = 0;
    r_nib.delete();
    sz = sel ? tb_q.size() : ta_q.size();
    for (int i = from; i < sz && ph < 3; i++) begin
      t = sel ? tb_q[i] : ta_q[i];
      if (ph < 2) begin
        if (t.cen) begin
          r_cen++;
          if (t.sof && r_sof == 0) r_sof = r_cen;
          if (t.eof && r_eof == 0) r_eof = r_cen;
        end
        if (t.und) r_und++;
        if (t.rdy) r_rdy++;
      end
      if (ph == 0 && t.en) begin ph = 1; r_first = i; end
      if (ph == 1) begin
        if (t.en) begin
          r_len++;
          if (t.er) begin
            r_er++;
            if (t.txd != 4'h0) r_mis++;
          end else begin
            r_nib.push_back(t.txd);
          end
        end else begin
          ph = 2; r_end = i - 1;
        end
      end
      if (ph == 2) begin
        if (t.en) ph = 3;
        else r_gap++;
      end
    end
    if (r_nib.size() != exp_q.size()) r_mis++;
    for (int i = 0; i < r_nib.size() && i < exp_q.size(); i++)
      if (r_nib[i] != exp_q[i]) r_mis++;
  endtask

  int from, n5, dmis, end1;
  logic [3:0] fcs_exp[8];

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; use_b = 1'b0;
    fcs_exp = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", {31'd0, en_a}, 32'd0);
    chk("rst_txd", {28'd0, txd_a}, 32'd0);
    chk("rst_tx_er", {31'd0, er_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_ready", {31'd0, rdy_a}, 32'd0);
    chk("rst_underrun", {31'd0, und_a}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 60-byte frame, no padding
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    build_exp(60);
    from = ta_q.size();
    send_frame(-1, 1'b1);
    wait_idle();
    analyze(1'b0, from);
    chk("f60_len", r_len, 144);
    n5 = 0;
    for (int i = 0; i < 15 && i < r_nib.size(); i++) if (r_nib[i] == 4'h5) n5++;
    chk("f60_pre5", n5, 15);
    if (r_nib.size() > 15) chk("f60_sfd", {28'd0, r_nib[15]}, 32'hD);
    chk("f60_nibbles", r_mis, 0);
    chk("f60_crc_en_count", r_cen, 120);
    chk("f60_eof_pos", r_eof, 120);

    // MIN_BYTES=0, "123456789"
    use_b = 1'b1;
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    from = tb_q.size();
    send_frame(-1, 1'b1);
    wait_idle();
    build_exp(0);
    analyze(1'b1, from);
    chk("chk9_len", r_len, 42);
    chk("chk9_nibcount", r_nib.size(), 42);
    if (r_nib.size() == 42) begin
      dmis = 0;
      for (int j = 0; j < 18; j++) begin
        if (j % 2 == 0) begin
          if (r_nib[16+j] != 4'(j/2 + 1)) dmis++;
        end else if (r_nib[16+j] != 4'h3) dmis++;
      end
      chk("chk9_data", dmis, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("chk9_fcs%0d", k), {28'd0, r_nib[34+k]}, {28'd0, fcs_exp[k]});
    end
    chk("chk9_sof_pos", r_sof, 1);
    chk("chk9_eof_pos", r_eof, 18);
    use_b = 1'b0;

    // 1-byte frame, padded to 60
    pay.delete(); pay.push_back(8'hAB);
    build_exp(60);
    from = ta_q.size();
    send_frame(-1, 1'b1);
    wait_idle();
    analyze(1'b0, from);
    chk("f1_len", r_len, 144);
    chk("f1_nibbles", r_mis, 0);
    chk("f1_sof_pos", r_sof, 1);
    chk("f1_eof_pos", r_eof, 120);
    chk("f1_ready_cycles", r_rdy, 1);

    // underrun: source stalls after byte 4
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'h10 + 8'(i));
    build_exp(60);
    from = ta_q.size();
    send_frame(4, 1'b1);
    wait_idle();
    analyze(1'b0, from);
    chk("ur_pulses", r_und, 3);
    chk("ur_er_nibbles", r_er, 3);
    chk("ur_len", r_len, 147);
    chk("ur_nibbles", r_mis, 0);

    // back-to-back frames with s_tvalid held
    pay.delete(); pay.push_back(8'hC0); pay.push_back(8'hC1);
    build_exp(60);
    from = ta_q.size();
    send_frame(-1, 1'b0);
    send_frame(-1, 1'b1);
    wait_idle();
    analyze(1'b0, from);
    chk("b2b_gap", r_gap, 24);
    chk("b2b_f1_nibbles", r_mis, 0);
    end1 = r_end;
    analyze(1'b0, end1 + 1);
    chk("b2b_f2_nibbles", r_mis, 0);
    chk("b2b_f2_len", r_len, 144);

    // reset asserted mid-DATA
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'h70 + 8'(i));
    for (int i = 0; i < 5; i++) push_byte(pay[i], 1'b0);
    s_tvalid = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_tx_en", {31'd0, en_a}, 32'd0);
    chk("mrst_txd", {28'd0, txd_a}, 32'd0);
    chk("mrst_busy", {31'd0, busy_a}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    pay.delete(); pay.push_back(8'h5A);
    build_exp(60);
    from = ta_q.size();
    send_frame(-1, 1'b1);
    wait_idle();
    analyze(1'b0, from);
    chk("mrst_next_len", r_len, 144);
    chk("mrst_next_nibbles", r_mis, 0);
    chk("mrst_next_sof", r_sof, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
